// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-access path.
// Contents:
//   ADDR_W, DATA_W - address / data widths of the data memory port
//   WORD_SPAN      - memory slots touched by one word access (Address..Address+WORD_SPAN-1)
//   sb_entry_t     - one buffered store {addr, data}
//   sb_overlaps    - true when two word accesses share at least one slot
package cpu_mem_pkg;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int WORD_SPAN = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    // Distance is measured both ways round the address ring so that
    // accesses straddling the top of memory (e.g. 0xFFFE vs 0x0001) overlap.
    function automatic logic sb_overlaps(input logic [ADDR_W-1:0] a,
                                         input logic [ADDR_W-1:0] b);
        logic [ADDR_W-1:0] fwd;
        logic [ADDR_W-1:0] bwd;
        fwd = a - b;
        bwd = b - a;
        return (fwd < ADDR_W'(WORD_SPAN)) || (bwd < ADDR_W'(WORD_SPAN));
    endfunction
endpackage

// File: rtl/store_buffer_if.sv
// Bus bundle between the CPU memory stage, the store buffer and DataMem.
// CPU side : Address, WriteData, MemWrite, MemRead -> ReadData, Stall, Empty, Count
// Mem side : MemAddress, MemWriteData, MemWriteEn, MemReadEn -> MemReadData
// Modports : slave  = the store buffer itself
//            master = its environment (CPU stage plus DataMem)
interface store_buffer_if #(parameter int DEPTH = 4);
    import cpu_mem_pkg::*;

    logic [ADDR_W-1:0]        Address;
    logic [DATA_W-1:0]        WriteData;
    logic                     MemWrite;
    logic                     MemRead;
    logic [DATA_W-1:0]        ReadData;
    logic                     Stall;
    logic                     Empty;
    logic [$clog2(DEPTH):0]   Count;
    logic [ADDR_W-1:0]        MemAddress;
    logic [DATA_W-1:0]        MemWriteData;
    logic                     MemWriteEn;
    logic                     MemReadEn;
    logic [DATA_W-1:0]        MemReadData;

    modport slave (
        input  Address, WriteData, MemWrite, MemRead, MemReadData,
        output ReadData, Stall, Empty, Count,
        output MemAddress, MemWriteData, MemWriteEn, MemReadEn
    );

    modport master (
        output Address, WriteData, MemWrite, MemRead, MemReadData,
        input  ReadData, Stall, Empty, Count,
        input  MemAddress, MemWriteData, MemWriteEn, MemReadEn
    );
endinterface

// File: rtl/sb_match.sv
// Youngest-first overlap search over the store buffer entries.
// Ports:
//   entries  - all FIFO slots (only those with valid set are considered)
//   valid    - per-slot occupancy
//   tail     - next free slot; tail-1 is the youngest entry
//   addr     - load address being checked
//   hit      - some valid entry overlaps addr
//   exact    - the youngest overlapping entry has exactly addr
//   hit_data - data of the youngest overlapping entry
module sb_match import cpu_mem_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  sb_entry_t [DEPTH-1:0]      entries,
    input  logic [DEPTH-1:0]           valid,
    input  logic [$clog2(DEPTH)-1:0]   tail,
    input  logic [ADDR_W-1:0]          addr,
    output logic                       hit,
    output logic                       exact,
    output logic [DATA_W-1:0]          hit_data
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] ovl;
    logic [DEPTH-1:0] eq;
    logic [PTR_W-1:0] idx;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign ovl[gi] = valid[gi] && sb_overlaps(entries[gi].addr, addr);
        assign eq[gi]  = (entries[gi].addr == addr);
    end

    // Walk from oldest (tail-DEPTH) to youngest (tail-1); each later hit
    // overrides the earlier one, so the youngest overlapping entry wins.
    always_comb begin
        hit      = 1'b0;
        exact    = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = tail - PTR_W'(k + 1);
            if (ovl[idx]) begin
                hit      = 1'b1;
                exact    = eq[idx];
                hit_data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// Store buffer between the CPU memory stage and DataMem.
// Stores are queued in a DEPTH-entry circular FIFO and drained one per cycle
// whenever no load is using the memory port. Loads forward from the youngest
// exactly-matching buffered store, read DataMem when nothing overlaps, and
// stall while only a partial overlap exists.
// Ports:
//   Clock  - single clock, rising edge
//   ResetN - asynchronous active-low reset; discards every buffered store
//   bus    - store_buffer_if.slave: CPU request/response and DataMem port
module store_buffer import cpu_mem_pkg::*; #(
    parameter int DEPTH = 4
) (
    input logic           Clock,
    input logic           ResetN,
    store_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t [DEPTH-1:0] entries_reg;
    logic [DEPTH-1:0]      valid_reg;
    logic [PTR_W-1:0]      head_reg;
    logic [PTR_W-1:0]      tail_reg;
    logic [CNT_W-1:0]      count_reg;

    logic                  hit;
    logic                  exact;
    logic [DATA_W-1:0]     hit_data;
    logic                  full;
    logic                  partial;
    logic                  stall;
    logic                  load_port;
    logic                  drain;
    logic                  enqueue;

    sb_match #(.DEPTH(DEPTH)) u_match (
        .entries  (entries_reg),
        .valid    (valid_reg),
        .tail     (tail_reg),
        .addr     (bus.Address),
        .hit      (hit),
        .exact    (exact),
        .hit_data (hit_data)
    );

    always_comb begin
        full    = (count_reg == CNT_W'(DEPTH));
        partial = bus.MemRead && hit && !exact;
        stall   = (bus.MemWrite && full) || partial;
        // Only an unstalled, non-forwarded load claims the port. A load held
        // by a full-buffer stall must give the port up, otherwise the drain
        // that frees a slot could never happen. ResetN keeps the port idle
        // while reset is asserted.
        load_port = ResetN && bus.MemRead && !hit && !stall;
        drain     = (count_reg != '0) && !load_port;
        // A stalled request is re-presented next cycle, so it is not taken now.
        enqueue   = bus.MemWrite && !stall;
    end

    assign bus.Stall        = stall;
    assign bus.Empty        = (count_reg == '0);
    assign bus.Count        = count_reg;
    assign bus.MemReadEn    = load_port;
    assign bus.MemWriteEn   = drain;
    assign bus.MemAddress   = drain ? entries_reg[head_reg].addr : bus.Address;
    assign bus.MemWriteData = entries_reg[head_reg].data;
    assign bus.ReadData     = (hit && exact) ? hit_data : bus.MemReadData;

    // Control state: pointers, count and occupancy.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
        end else begin
            // A drained slot and an enqueued slot can never coincide: that
            // would need head==tail, i.e. an empty or a full buffer.
            if (drain) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PTR_W'(1);
            end
            if (enqueue) begin
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(enqueue) - CNT_W'(drain);
        end
    end

    // Payload storage needs no reset: stale slots are masked by valid_reg.
    always_ff @(posedge Clock) begin
        if (enqueue) begin
            entries_reg[tail_reg] <= '{addr: bus.Address, data: bus.WriteData};
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, reset-mid-drain
// sequence, then randomized traffic against a queue-based reference model.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic Clock;
    logic ResetN;
    int   checks = 0;
    int   fails  = 0;
    int   wr_count = 0;

    store_buffer_if #(.DEPTH(DEPTH)) sb_bus();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (sb_bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // DataMem stand-in: combinational read, write on posedge.
    logic [15:0] mem [65536];
    assign sb_bus.MemReadData = mem[sb_bus.MemAddress];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] <= 16'(i) ^ 16'hA5A5;
        forever begin
            @(posedge Clock);
            if (sb_bus.MemWriteEn) begin
                mem[sb_bus.MemAddress] <= sb_bus.MemWriteData;
                wr_count = wr_count + 1;
            end
        end
    end

    // Reference model: plain queue of pending stores plus expected memory image.
    typedef struct { logic [15:0] addr; logic [15:0] data; } ment_t;
    ment_t       model_q[$];
    logic [15:0] ref_mem [65536];

    function automatic bit m_ovl(input logic [15:0] e, input logic [15:0] r);
        int d;
        d = (int'(r) - int'(e) + 65536) % 65536;
        return (d < 4) || (d > 65532);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: apply inputs after the falling edge, check against the model.
    task automatic drive(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        int  idx;
        bit  found;
        bit  e_stall, e_rden, e_wren;
        int  n;
        @(negedge Clock);
        sb_bus.MemRead   = rd;
        sb_bus.MemWrite  = wr;
        sb_bus.Address   = a;
        sb_bus.WriteData = d;
        #1;
        n = model_q.size();
        found = 1'b0;
        idx = 0;
        for (int i = n - 1; i >= 0; i--) begin
            if (m_ovl(model_q[i].addr, a)) begin
                found = 1'b1;
                idx = i;
                break;
            end
        end
        e_stall = (wr && n == DEPTH) || (rd && found && model_q[idx].addr != a);
        e_rden  = rd && !found && !e_stall;
        e_wren  = (n > 0) && !e_rden;
        chk("m_stall", sb_bus.Stall, e_stall);
        chk("m_rden", sb_bus.MemReadEn, e_rden);
        chk("m_wren", sb_bus.MemWriteEn, e_wren);
        chk("m_count", 32'(sb_bus.Count), n);
        chk("m_empty", sb_bus.Empty, n == 0);
        chk("m_excl", sb_bus.MemReadEn && sb_bus.MemWriteEn, 0);
        if (e_rden) chk("m_maddr_rd", sb_bus.MemAddress, a);
        if (e_wren) begin
            chk("m_maddr_wr", sb_bus.MemAddress, model_q[0].addr);
            chk("m_mwdata", sb_bus.MemWriteData, model_q[0].data);
        end
        if (rd && !e_stall)
            chk("m_rdata", sb_bus.ReadData, found ? model_q[idx].data : ref_mem[a]);
        $display("t=%0t rd=%0b wr=%0b addr=%h wdata=%h stall=%0b rden=%0b wren=%0b count=%0d rdata=%h",
                 $time, rd, wr, a, d, sb_bus.Stall, sb_bus.MemReadEn, sb_bus.MemWriteEn,
                 sb_bus.Count, sb_bus.ReadData);
        if (e_wren) begin
            ref_mem[model_q[0].addr] = model_q[0].data;
            void'(model_q.pop_front());
        end
        if (wr && !e_stall) model_q.push_back('{a, d});
    endtask

    // Directed vectors with hand-derived expectations.
    typedef struct {
        bit rd; bit wr; logic [15:0] addr; logic [15:0] wdata;
        bit stall; bit rden; bit wren; int cnt;
        logic [15:0] maddr; logic [15:0] mwdata; bit chk_rd; logic [15:0] rdata;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                       input bit st, input bit re, input bit we, input int c,
                       input logic [15:0] ma, input logic [15:0] mwd,
                       input bit cr, input logic [15:0] rdv);
        tbl.push_back('{rd, wr, a, d, st, re, we, c, ma, mwd, cr, rdv});
    endtask

    int wcnt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = 16'(i) ^ 16'hA5A5;
        sb_bus.MemRead = 1'b1; sb_bus.MemWrite = 1'b0;
        sb_bus.Address = 16'h0123; sb_bus.WriteData = 16'h0;
        ResetN = 1'b1;
        #2 ResetN = 1'b0;

        // Reset state, with a load request present to prove the port stays idle.
        @(negedge Clock); #1;
        chk("rst_count", 32'(sb_bus.Count), 0);
        chk("rst_empty", sb_bus.Empty, 1);
        chk("rst_stall", sb_bus.Stall, 0);
        chk("rst_wren", sb_bus.MemWriteEn, 0);
        chk("rst_rden", sb_bus.MemReadEn, 0);
        chk("rst_rdata", sb_bus.ReadData, sb_bus.MemReadData);
        @(negedge Clock);
        sb_bus.MemRead = 1'b0;
        ResetN = 1'b1;

        //   rd wr addr      wdata    st re we cnt maddr     mwdata  crd rdata
        add(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0010, 16'hBEEF, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(1, 1, 16'h0040, 16'h4444, 0, 1, 0, 0, 16'h0040, 16'h0000, 1, 16'hA5E5);
        add(1, 1, 16'h0020, 16'h1111, 0, 1, 0, 1, 16'h0020, 16'h0000, 1, 16'hA585);
        add(0, 1, 16'h0020, 16'h2222, 0, 0, 1, 2, 16'h0040, 16'h4444, 0, 16'h0000);
        add(1, 0, 16'h0020, 16'h0000, 0, 0, 1, 2, 16'h0020, 16'h1111, 1, 16'h2222);
        add(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0020, 16'h2222, 0, 16'h0000);
        add(1, 1, 16'h0000, 16'hA000, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'hA5A5);
        add(1, 1, 16'h0004, 16'hA004, 0, 1, 0, 1, 16'h0004, 16'h0000, 1, 16'hA5A1);
        add(1, 1, 16'h0008, 16'hA008, 0, 1, 0, 2, 16'h0008, 16'h0000, 1, 16'hA5AD);
        add(1, 1, 16'h000C, 16'hA00C, 0, 1, 0, 3, 16'h000C, 16'h0000, 1, 16'hA5A9);
        add(1, 1, 16'h0010, 16'hA010, 1, 0, 1, 4, 16'h0000, 16'hA000, 0, 16'h0000);
        add(1, 1, 16'h0010, 16'hA010, 0, 1, 0, 3, 16'h0010, 16'h0000, 1, 16'hBEEF);
        add(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 4, 16'h0004, 16'hA004, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 3, 16'h0008, 16'hA008, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 2, 16'h000C, 16'hA00C, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0010, 16'hA010, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0030, 16'h3030, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(1, 0, 16'h0032, 16'h0000, 1, 0, 1, 1, 16'h0030, 16'h3030, 0, 16'h0000);
        add(1, 0, 16'h0032, 16'h0000, 0, 1, 0, 0, 16'h0032, 16'h0000, 1, 16'hA597);
        add(0, 1, 16'hFFFE, 16'hFEFE, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(1, 0, 16'h0001, 16'h0000, 1, 0, 1, 1, 16'hFFFE, 16'hFEFE, 0, 16'h0000);
        add(1, 0, 16'h0001, 16'h0000, 0, 1, 0, 0, 16'h0001, 16'h0000, 1, 16'hA5A4);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            chk($sformatf("tbl%0d_stall", i), sb_bus.Stall, tbl[i].stall);
            chk($sformatf("tbl%0d_rden", i), sb_bus.MemReadEn, tbl[i].rden);
            chk($sformatf("tbl%0d_wren", i), sb_bus.MemWriteEn, tbl[i].wren);
            chk($sformatf("tbl%0d_count", i), 32'(sb_bus.Count), tbl[i].cnt);
            chk($sformatf("tbl%0d_empty", i), sb_bus.Empty, tbl[i].cnt == 0);
            if (tbl[i].rden || tbl[i].wren)
                chk($sformatf("tbl%0d_maddr", i), sb_bus.MemAddress, tbl[i].maddr);
            if (tbl[i].wren)
                chk($sformatf("tbl%0d_mwdata", i), sb_bus.MemWriteData, tbl[i].mwdata);
            if (tbl[i].chk_rd)
                chk($sformatf("tbl%0d_rdata", i), sb_bus.ReadData, tbl[i].rdata);
        end

        // Reset asserted while a drain is in progress.
        drive(1, 1, 16'h0100, 16'h0001);
        drive(1, 1, 16'h0200, 16'h0002);
        drive(1, 1, 16'h0300, 16'h0003);
        drive(0, 0, 16'h0000, 16'h0000);
        @(negedge Clock);
        sb_bus.MemRead = 1'b0; sb_bus.MemWrite = 1'b0;
        #1;
        chk("t6_drain_active", sb_bus.MemWriteEn, 1);
        chk("t6_count_before", 32'(sb_bus.Count), 2);
        wcnt = wr_count;
        ResetN = 1'b0;
        sb_bus.MemRead = 1'b1;
        sb_bus.Address = 16'h0500;
        #1;
        chk("t6_count", 32'(sb_bus.Count), 0);
        chk("t6_empty", sb_bus.Empty, 1);
        chk("t6_wren", sb_bus.MemWriteEn, 0);
        chk("t6_rden", sb_bus.MemReadEn, 0);
        chk("t6_stall", sb_bus.Stall, 0);
        chk("t6_rdata", sb_bus.ReadData, sb_bus.MemReadData);
        @(negedge Clock);
        chk("t6_no_write_in_reset", wr_count, wcnt);
        sb_bus.MemRead = 1'b0;
        ResetN = 1'b1;
        model_q.delete();
        drive(0, 0, 16'h0000, 16'h0000);
        drive(0, 0, 16'h0000, 16'h0000);
        drive(1, 0, 16'h0200, 16'h0000);
        chk("t6_no_write_after", wr_count, wcnt);
        chk("t6_mem200", mem[16'h0200], 16'h0200 ^ 16'hA5A5);
        chk("t6_mem300", mem[16'h0300], 16'h0300 ^ 16'hA5A5);

        // Randomized traffic around the address wrap point.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) != 0,
                  16'(16'hFFF8 + $urandom_range(0, 15)),
                  16'($urandom));
        end
        // Let the buffer empty and confirm memory holds every store.
        for (int i = 0; i < DEPTH + 1; i++) drive(0, 0, 16'h0000, 16'h0000);
        for (int a = 0; a < 16; a++) begin
            chk($sformatf("final_mem_%0d", a), mem[16'(16'hFFF8 + a)], ref_mem[16'(16'hFFF8 + a)]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
